// File: rtl/uart_receiver_pkg.sv
// Shared constants and state encoding for the UART receiver.
// Imported by the tick divider and the receiver top.
package uart_receiver_pkg;

    localparam int OVERSAMPLE   = 16;
    localparam int DATA_BITS    = 8;
    localparam int BAUD_DIV_DEF = 27;

    localparam int SCNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [SCNT_W-1:0] MID_TICK = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] END_TICK = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Serial line in, received byte and status pulses out.
// master = line driver / byte consumer, slave = receiver.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic                 rx;
    logic                 Rx_tick;
    logic [DATA_BITS-1:0] Dout;
    logic                 frame_err;

    modport master (
        output rx,
        input  Rx_tick,
        input  Dout,
        input  frame_err
    );

    modport slave (
        input  rx,
        output Rx_tick,
        output Dout,
        output frame_err
    );

endinterface

// File: rtl/uart_receiver_tick.sv
// Oversample tick divider: counts 0..BAUD_DIV-1 while enabled,
// held at zero while disabled so every frame starts phase-aligned.
module baud_tick_gen
    import uart_receiver_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(BAUD_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, glitch rejection on the
// start bit, framing-error detection and break handling.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_receiver_if.slave bus
);

    logic                 r_sync1;
    logic                 r_rx_s;
    state_e               r_state;
    state_e               w_next;
    logic [SCNT_W-1:0]    r_scnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_rx_tick;
    logic                 r_ferr;

    logic w_en;
    logic w_tick;
    logic w_mid;
    logic w_end;
    logic w_scnt_clr;
    logic w_shift_en;
    logic w_bit_clr;
    logic w_load;
    logic w_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_en = (r_state != ST_IDLE);

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .tick  (w_tick)
    );

    assign w_mid = w_tick && (r_scnt == MID_TICK);
    assign w_end = w_tick && (r_scnt == END_TICK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) w_next = ST_START;
            end
            ST_START: begin
                if (w_mid) w_next = r_rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_end && r_bit == LAST_BIT) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_end) w_next = r_rx_s ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                if (r_rx_s) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Sample counter restarts on every state change so each phase
    // measures its own 8- or 16-tick interval from zero.
    always_comb begin
        w_scnt_clr = 1'b0;
        w_shift_en = 1'b0;
        w_bit_clr  = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_scnt_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
            ST_START: begin
                w_scnt_clr = w_mid;
                w_bit_clr  = 1'b1;
            end
            ST_DATA: begin
                w_scnt_clr = w_end;
                w_shift_en = w_end;
            end
            ST_STOP: begin
                w_scnt_clr = w_end;
                w_load     = w_end && r_rx_s;
                w_ferr     = w_end && !r_rx_s;
            end
            ST_BREAK: begin
                w_scnt_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
            default: begin
                w_scnt_clr = 1'b1;
                w_bit_clr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scnt <= '0;
        end else if (w_scnt_clr) begin
            r_scnt <= '0;
        end else if (w_tick) begin
            r_scnt <= r_scnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_rx_tick <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_tick <= w_load;
            r_ferr    <= w_ferr;
            if (w_load) begin
                r_dout <= r_shift;
            end
        end
    end

    assign bus.Rx_tick   = r_rx_tick;
    assign bus.Dout      = r_dout;
    assign bus.frame_err = r_ferr;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at BAUD_DIV = 4 (64 clk per bit).
// Frame vectors from a table plus hand-written corner sequences.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int DIV = 4;
    localparam int BIT = DIV * OVERSAMPLE;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_ticks;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    logic clk;
    logic rst_n;

    uart_receiver_if bus ();

    uart_receiver #(
        .BAUD_DIV (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int n_tick = 0;
    int n_ferr = 0;
    int n_both = 0;
    int t_tick = 0;
    int t0     = 0;
    logic [7:0] dq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Rx_tick) begin
                n_tick = n_tick + 1;
                t_tick = cyc;
                dq.push_back(bus.Dout);
            end
            if (bus.frame_err) n_ferr = n_ferr + 1;
            if (bus.Rx_tick && bus.frame_err) n_both = n_both + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_tick = 0;
        n_ferr = 0;
        dq.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        wait_clk(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vt[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vt[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vt[3] = '{8'h5A, 1'b1, 1, 0, 8'h5A};
        vt[4] = '{8'hC3, 1'b0, 0, 1, 8'h5A};
        vt[5] = '{8'h81, 1'b1, 1, 0, 8'h81};

        bus.rx = 1'b1;
        rst_n  = 1'b0;
        wait_clk(5);
        chk("rst_dout", int'(bus.Dout), 0);
        chk("rst_rx_tick", int'(bus.Rx_tick), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        rst_n = 1'b1;
        wait_clk(10);

        // first frame: content and start-edge to Rx_tick latency
        clr_mon();
        send_frame(8'hA5, 1'b1);
        wait_clk(32);
        chk("a5_ticks", n_tick, 1);
        chk("a5_ferr", n_ferr, 0);
        chk("a5_dout", int'(bus.Dout), 8'hA5);
        n_vec = n_vec + 1;
        if (n_tick != 1 || t_tick - t0 < 610 || t_tick - t0 > 612) begin
            n_err = n_err + 1;
            $display("FAIL a5_latency: got %0d expected 611+-1", t_tick - t0);
        end

        for (int i = 0; i < 6; i++) begin
            clr_mon();
            send_frame(vt[i].data, vt[i].stop);
            bus.rx = 1'b1;
            wait_clk(32);
            chk($sformatf("vec%0d_ticks", i), n_tick, vt[i].exp_ticks);
            chk($sformatf("vec%0d_ferr", i), n_ferr, vt[i].exp_ferr);
            chk($sformatf("vec%0d_dout", i), int'(bus.Dout),
                int'(vt[i].exp_dout));
        end

        // start-bit glitch shorter than half a bit
        clr_mon();
        bus.rx = 1'b0;
        wait_clk(20);
        bus.rx = 1'b1;
        wait_clk(100);
        chk("glitch_ticks", n_tick, 0);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_state", int'(dut.r_state), int'(ST_IDLE));

        // framing error followed by a held-low break
        clr_mon();
        send_frame(8'h3C, 1'b0);
        wait_clk(200);
        chk("brk_ferr", n_ferr, 1);
        chk("brk_ticks", n_tick, 0);
        chk("brk_dout", int'(bus.Dout), 8'h81);
        chk("brk_state", int'(dut.r_state), int'(ST_BREAK));
        bus.rx = 1'b1;
        wait_clk(20);
        chk("brk_exit", int'(dut.r_state), int'(ST_IDLE));
        chk("brk_quiet", n_tick + n_ferr, 1);

        // back-to-back frames, no idle gap
        clr_mon();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_clk(32);
        chk("b2b_ticks", n_tick, 2);
        chk("b2b_ferr", n_ferr, 0);
        chk("b2b_first", dq.size() > 0 ? int'(dq[0]) : -1, 8'h00);
        chk("b2b_second", dq.size() > 1 ? int'(dq[1]) : -1, 8'hFF);

        // reset in the middle of data bit 4 of 0x81
        clr_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        bus.rx = 1'b0;
        wait_clk(32);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", int'(bus.Dout), 0);
        chk("mid_rst_tick", int'(bus.Rx_tick), 0);
        wait_clk(10);
        bus.rx = 1'b1;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(300);
        chk("abort_ticks", n_tick, 0);
        chk("abort_ferr", n_ferr, 0);
        send_frame(8'h42, 1'b1);
        wait_clk(32);
        chk("post_rst_ticks", n_tick, 1);
        chk("post_rst_dout", int'(bus.Dout), 8'h42);
        chk("post_rst_ferr", n_ferr, 0);

        chk("tick_ferr_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
